// File: rtl/game_clock_ctrl.sv
// Seconds display sequencer: 1 s prescaler, start/pause/clear FSM,
// three-digit BCD up/down counter with a one-cycle time_up event.
module game_clock_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESCALE_W    = 26
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    input  logic        count_down,
    input  logic [11:0] load_val,
    output logic [3:0]  one_sec,
    output logic [3:0]  ten_sec,
    output logic [3:0]  hund_sec,
    output logic        sec_tick,
    output logic        running,
    output logic        paused,
    output logic        time_up
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRESC_MAX =
        PRESCALE_W'(TICKS_PER_SEC - 1);

    state_t                state;
    logic                  mode;
    logic [PRESCALE_W-1:0] presc;
    logic                  expire_evt;
    logic [11:0]           digits;
    logic [11:0]           load_clamped;
    logic [11:0]           digits_inc;
    logic [11:0]           digits_dec;
    logic                  tick;
    logic                  pause_cmd;

    function automatic logic [3:0] clamp9(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    assign digits    = {hund_sec, ten_sec, one_sec};
    assign tick      = (state == RUN) && (presc == PRESC_MAX);
    // start outranks pause even in RUN, where start itself does nothing
    assign pause_cmd = pause && !start;

    // Countdown preload with every nibble limited to a legal BCD digit
    always_comb begin
        load_clamped = {clamp9(load_val[11:8]),
                        clamp9(load_val[7:4]),
                        clamp9(load_val[3:0])};
    end

    // BCD increment with carry ripple, 999 wraps to 000
    always_comb begin
        digits_inc = digits;
        if (one_sec != 4'd9) begin
            digits_inc[3:0] = one_sec + 4'd1;
        end else begin
            digits_inc[3:0] = 4'd0;
            if (ten_sec != 4'd9) begin
                digits_inc[7:4] = ten_sec + 4'd1;
            end else begin
                digits_inc[7:4]  = 4'd0;
                digits_inc[11:8] = (hund_sec == 4'd9) ? 4'd0
                                                      : hund_sec + 4'd1;
            end
        end
    end

    // BCD decrement with borrow ripple
    always_comb begin
        digits_dec = digits;
        if (one_sec != 4'd0) begin
            digits_dec[3:0] = one_sec - 4'd1;
        end else begin
            digits_dec[3:0] = 4'd9;
            if (ten_sec != 4'd0) begin
                digits_dec[7:4] = ten_sec - 4'd1;
            end else begin
                digits_dec[7:4]  = 4'd9;
                digits_dec[11:8] = (hund_sec == 4'd0) ? 4'd9
                                                      : hund_sec - 4'd1;
            end
        end
    end

    // Control FSM, prescaler, digit register and registered status outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state                        <= IDLE;
            mode                         <= 1'b0;
            presc                        <= '0;
            expire_evt                   <= 1'b0;
            {hund_sec, ten_sec, one_sec} <= 12'h000;
            sec_tick                     <= 1'b0;
            running                      <= 1'b0;
            paused                       <= 1'b0;
            time_up                      <= 1'b0;
        end else begin
            sec_tick   <= 1'b0;
            expire_evt <= 1'b0;
            time_up    <= expire_evt;
            if (clear) begin
                state                        <= IDLE;
                presc                        <= '0;
                {hund_sec, ten_sec, one_sec} <= 12'h000;
                running                      <= 1'b0;
                paused                       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, EXPIRED: begin
                        if (start) begin
                            mode  <= count_down;
                            presc <= '0;
                            paused <= 1'b0;
                            if (!count_down) begin
                                {hund_sec, ten_sec, one_sec} <= 12'h000;
                                state   <= RUN;
                                running <= 1'b1;
                            end else if (load_clamped == 12'h000) begin
                                {hund_sec, ten_sec, one_sec} <= 12'h000;
                                state      <= EXPIRED;
                                running    <= 1'b0;
                                expire_evt <= 1'b1;
                            end else begin
                                {hund_sec, ten_sec, one_sec} <= load_clamped;
                                state   <= RUN;
                                running <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            presc    <= '0;
                            sec_tick <= 1'b1;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                        if (tick && mode && digits == 12'h001) begin
                            {hund_sec, ten_sec, one_sec} <= 12'h000;
                            state      <= EXPIRED;
                            running    <= 1'b0;
                            paused     <= 1'b0;
                            expire_evt <= 1'b1;
                        end else begin
                            if (tick) begin
                                {hund_sec, ten_sec, one_sec} <=
                                    mode ? digits_dec : digits_inc;
                            end
                            if (pause_cmd) begin
                                state   <= PAUSE;
                                running <= 1'b0;
                                paused  <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (start || pause) begin
                            state   <= RUN;
                            running <= 1'b1;
                            paused  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Scoreboard bench for game_clock_ctrl with a 4-cycle second.
// Stimulus queues expected tick/time_up events; a monitor checks them.
module tb_game_clock_ctrl;

    localparam int TPS = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;
    logic        count_down = 1'b0;
    logic [11:0] load_val = 12'h000;
    logic [3:0]  one_sec;
    logic [3:0]  ten_sec;
    logic [3:0]  hund_sec;
    logic        sec_tick;
    logic        running;
    logic        paused;
    logic        time_up;
    logic [11:0] dig;

    game_clock_ctrl #(
        .TICKS_PER_SEC(TPS),
        .PRESCALE_W(3)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .start(start),
        .pause(pause),
        .clear(clear),
        .count_down(count_down),
        .load_val(load_val),
        .one_sec(one_sec),
        .ten_sec(ten_sec),
        .hund_sec(hund_sec),
        .sec_tick(sec_tick),
        .running(running),
        .paused(paused),
        .time_up(time_up)
    );

    assign dig = {hund_sec, ten_sec, one_sec};

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        tick;
        logic        tu;
        logic [11:0] dig;
        logic        run;
        logic        pau;
        int          at;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;

    function automatic logic [11:0] bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic expect_ev(input bit tk, input bit tu, input int v,
                             input bit run, input bit pau, input int at);
        ev_t e;
        e.tick = tk;
        e.tu   = tu;
        e.dig  = bcd(v);
        e.run  = run;
        e.pau  = pau;
        e.at   = at;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Monitor: every sec_tick or time_up must match the next queued event
    always @(negedge Clk) begin
        if (!Reset && (sec_tick || time_up)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event tick=%0b time_up=%0b dig=%h cyc=%0d",
                         sec_tick, time_up, dig, cyc);
            end else begin
                mon_e = q.pop_front();
                if ({sec_tick, time_up, dig, running, paused} !==
                    {mon_e.tick, mon_e.tu, mon_e.dig, mon_e.run, mon_e.pau}
                    || cyc != mon_e.at) begin
                    failures++;
                    $display("FAIL event actual tick=%0b tu=%0b dig=%h run=%0b pau=%0b cyc=%0d required tick=%0b tu=%0b dig=%h run=%0b pau=%0b cyc=%0d",
                             sec_tick, time_up, dig, running, paused, cyc,
                             mon_e.tick, mon_e.tu, mon_e.dig, mon_e.run,
                             mon_e.pau, mon_e.at);
                end
            end
        end
    end

    task automatic do_start(input bit cd, input logic [11:0] lv,
                            output int k);
        count_down = cd;
        load_val   = lv;
        start      = 1'b1;
        cycles(1);
        start = 1'b0;
        k = cyc;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
    endtask

    initial begin
        int k;
        int p;
        int r;

        // Reset state
        #2 Reset = 1'b1;
        cycles(2);
        chk("reset_digits", dig, 12'h000);
        chk("reset_flags", {sec_tick, running, paused, time_up}, 4'b0000);
        Reset = 1'b0;
        cycles(2);

        // Up count through 999 wrap to 001
        do_start(1'b0, 12'h000, k);
        chk("up_start_dig", dig, 12'h000);
        chk("up_running", {running, paused}, 2'b10);
        for (int i = 1; i <= 1001; i++)
            expect_ev(1, 0, i % 1000, 1, 0, k + TPS * i);
        cycles(TPS * 1001 + 2);
        chk("up_after_wrap", dig, 12'h001);
        chk("up_drained", 16'(q.size()), 16'd0);
        do_clear();
        chk("clear_idle", {dig, running, paused}, {12'h000, 2'b00});

        // Down count from 010 to expiry
        do_start(1'b1, 12'h010, k);
        chk("down_load", dig, 12'h010);
        for (int i = 1; i <= 9; i++)
            expect_ev(1, 0, 10 - i, 1, 0, k + TPS * i);
        expect_ev(1, 0, 0, 0, 0, k + TPS * 10);
        expect_ev(0, 1, 0, 0, 0, k + TPS * 10 + 1);
        cycles(TPS * 10 + 5);
        chk("down_expired", {dig, running, paused}, {12'h000, 2'b00});
        chk("down_drained", 16'(q.size()), 16'd0);

        // Pause two cycles after a tick, preserving the partial second
        do_start(1'b0, 12'h000, k);
        expect_ev(1, 0, 1, 1, 0, k + TPS);
        cycles(5);
        pause = 1'b1;
        cycles(1);
        pause = 1'b0;
        p = cyc;
        chk("pause_flags", {running, paused}, 2'b01);
        cycles(20);
        chk("pause_hold_dig", dig, 12'h001);
        chk("pause_hold_flags", {running, paused}, 2'b01);
        pause = 1'b1;
        cycles(1);
        pause = 1'b0;
        r = cyc;
        chk("resume_at", r, p + 21);
        chk("resume_flags", {running, paused}, 2'b10);
        expect_ev(1, 0, 2, 1, 0, r + 2);
        cycles(4);
        chk("pause_drained", 16'(q.size()), 16'd0);
        do_clear();

        // Countdown load of zero expires at once; clamped loads
        do_start(1'b1, 12'h000, k);
        chk("zero_load", {dig, running, paused}, {12'h000, 2'b00});
        expect_ev(0, 1, 0, 0, 0, k + 1);
        cycles(TPS + 2);
        chk("zero_drained", 16'(q.size()), 16'd0);
        do_start(1'b1, 12'h0AF, k);
        chk("clamp_0af", dig, 12'h099);
        do_clear();
        do_start(1'b1, 12'h1A5, k);
        chk("clamp_1a5", dig, 12'h195);
        do_clear();

        // Clear coinciding with a tick wins
        do_start(1'b0, 12'h000, k);
        cycles(TPS - 1);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        chk("clear_tick_at", cyc, k + TPS);
        chk("clear_tick", {dig, sec_tick, running}, {12'h000, 2'b00});
        cycles(2 * TPS);
        chk("clear_no_events", 16'(q.size()), 16'd0);

        // Asynchronous reset mid-count
        do_start(1'b0, 12'h000, k);
        expect_ev(1, 0, 1, 1, 0, k + TPS);
        cycles(TPS + 2);
        chk("pre_reset_dig", dig, 12'h001);
        #2 Reset = 1'b1;
        #1;
        chk("async_reset",
            {dig, sec_tick, running, paused, time_up}, 16'h0000);
        cycles(1);
        Reset = 1'b0;
        cycles(3 * TPS);
        chk("post_reset_idle", {dig, running, paused}, {12'h000, 2'b00});

        cycles(2);
        chk("queue_final", 16'(q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_clock_ctrl.md
Name: game_clock_ctrl

Overview:
Sequencer for the on-screen three-digit seconds display. Generates the 1 s tick from the 50 MHz system clock and runs a start/pause/clear state machine. Maintains a BCD count that counts up (elapsed time) or down (time limit) and raises a one-cycle time_up event for the game FSM. Its digit outputs feed the digit-sprite renderers directly.

Parameters:
TICKS_PER_SEC, 50000000, Clk cycles per second tick (set to 4 in simulation); legal range is 2 or more.
PRESCALE_W, 26, prescaler width; must satisfy 2^PRESCALE_W >= TICKS_PER_SEC.

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  asynchronous, active-high; clock Clk
start  in  1  level sampled each cycle: begin or resume counting
pause  in  1  level sampled each cycle: toggles RUN and PAUSE
clear  in  1  level sampled each cycle: return to IDLE with digits 000
count_down  in  1  mode select, sampled only when start is accepted in IDLE or EXPIRED
load_val  in  12  BCD start value {hund,ten,one} for countdown mode
one_sec  out  4  BCD ones digit
ten_sec  out  4  BCD tens digit
hund_sec  out  4  BCD hundreds digit
sec_tick  out  1  one-cycle pulse on every counted second
running  out  1  high in RUN
paused  out  1  high in PAUSE
time_up  out  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- All outputs are registered. On Reset, with immediate effect: state is IDLE, prescaler is 0, and every output is 0.
- States are IDLE, RUN, PAUSE and EXPIRED. Command priority is clear > start > pause, with one command acted on per cycle.
- clear in any state: go to IDLE, digits become 000, prescaler becomes 0, sec_tick becomes 0.
- IDLE or EXPIRED with start: go to RUN, latch count_down into an internal mode bit, prescaler becomes 0.
  - Up mode: digits load 000.
  - Down mode: digits load load_val. Any nibble greater than 9 is clamped to 9 (for example, 0x1A5 loads 1,9,5).
  - Down mode with a loaded value of 000: go directly to EXPIRED and pulse time_up on the next cycle. No sec_tick is issued.
- RUN with pause (and no start or clear): go to PAUSE. The prescaler and digits are held, not reset.
- PAUSE with pause or start: go back to RUN. The prescaler continues from its held value, so partial seconds are preserved.
- start in RUN is ignored. pause in IDLE or EXPIRED is ignored.
- pause is level-sensitive. A pause held for N cycles toggles on every cycle, so the game FSM must issue one-cycle pulses.
- Prescaler in RUN counts 0 to TICKS_PER_SEC-1. On the edge where it holds TICKS_PER_SEC-1:
  - the prescaler returns to 0;
  - sec_tick is set to 1 for exactly one cycle;
  - the digits take their next value on that same edge.
- The first tick occurs TICKS_PER_SEC cycles after the edge that accepted start.
- Up mode arithmetic is a BCD increment with carry ripple: x9 to next ten, 99 to next hundred, 999 wraps to 000. The counter keeps running after a wrap.
- Down mode arithmetic is a BCD decrement with borrow ripple: x0 gives 9 in the ones digit with the tens digit decremented, and so on.
  - When the tick takes the value 001 to 000: digits show 000, sec_tick pulses, and the state goes to EXPIRED on the same edge.
  - time_up pulses on the following cycle.
- EXPIRED: digits hold 000, running is 0, the prescaler is frozen. Only start or clear leave this state.
- Simultaneous tick and pause in RUN: the tick completes (digits update, sec_tick pulses), and the state becomes PAUSE on the same edge.
- Simultaneous tick and clear: clear wins. Digits become 000 and no sec_tick is issued.
- running and paused decode the next state, so they change on the same edge as the state.
- Reset asserted mid-count: all registers clear immediately. Counting resumes only after a new start.

Test Plan:
- Reset, then start with count_down=0 and TICKS_PER_SEC=4 -> sec_tick on cycles 4, 8, 12; digits step 001, 002, 003; running=1.
- Up mode preloaded by forcing count 998, two ticks -> digits step 999 then 000, counting continues, time_up never asserts.
- Down mode with load_val=0x010 -> digits step 009, 008, and so on; after the tick to 000, time_up is one cycle high on the next cycle and state is EXPIRED.
- Pause pulse 2 cycles after a tick, wait 20 cycles, then pause pulse again -> the next tick arrives 2 cycles after resume and digits do not change during PAUSE.
- Down mode start with load_val=0x000 -> state goes to EXPIRED, one time_up pulse, zero sec_tick pulses. Separately, load_val=0x0AF loads 099.
- clear asserted on a tick cycle -> digits 000, no sec_tick; Reset asserted mid-RUN -> all outputs 0 immediately, counting does not restart until start.
